// File: rtl/fptoint_seq_ctrl.sv
// Command sequencer for the 4-lane FP-to-INT array: streams source vectors into the array and writes results back.
// Optional FPTOINT_SEQ_PERF_EN adds a saturating per-command cycle counter on perf_cnt.
module fptoint_seq_ctrl #(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  // cmd_vld/cmd_rdy: a command transfers on a rising edge where both are high; cmd_rdy is high only in IDLE.
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [ADDR_W-1:0] cmd_src_base,
  input  logic [ADDR_W-1:0] cmd_dst_base,
  input  logic [CNT_W-1:0]  cmd_len,
  input  logic [3:0]        cmd_cfg,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [127:0]      rd_data,
  output logic [127:0]      dvr_fptoint_s_in,
  output logic [4:0]        cru_fptoint_in,
  input  logic [127:0]      dr_fptoint_d_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [127:0]      wr_data,
  output logic              busy,
  output logic              done,
`ifdef FPTOINT_SEQ_PERF_EN
  output logic [31:0]       perf_cnt,
`endif
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [CNT_W-1:0]  rem_q;
  logic [3:0]        cfg_q;
  logic              drain_q;
  logic              rd_en_q;
  logic              s1_vld_q;
  logic              s2_vld_q;
  logic              cmd_rdy_q;
  logic              busy_q;
  logic              done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rem_q     <= '0;
      cfg_q     <= '0;
      drain_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      cmd_rdy_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // S1 = read data returning, S2 = array result registered
      s1_vld_q <= rd_en_q;
      s2_vld_q <= s1_vld_q;
      if (s2_vld_q) begin
        wr_addr_q <= wr_addr_q + ADDR_W'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (cmd_vld) begin
            rd_addr_q <= cmd_src_base;
            wr_addr_q <= cmd_dst_base;
            cfg_q     <= cmd_cfg;
            rem_q     <= cmd_len;
            cmd_rdy_q <= 1'b0;
            busy_q    <= 1'b1;
            if (cmd_len != '0) begin
              state_q <= S_RUN;
              rd_en_q <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          rd_addr_q <= rd_addr_q + ADDR_W'(1);
          rem_q     <= rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            rd_en_q <= 1'b0;
            drain_q <= 1'b0;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Two cycles let the last read pass through S1 and S2
          drain_q <= 1'b1;
          if (drain_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          done_q    <= 1'b0;
          cmd_rdy_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef FPTOINT_SEQ_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (cmd_vld) begin
        perf_q <= '0;
      end
    end else if (perf_q != 32'hFFFF_FFFF) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cnt = perf_q;
`endif

  assign cmd_rdy          = cmd_rdy_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign rd_en            = rd_en_q;
  assign rd_addr          = rd_addr_q;
  // Gated so the array sees zeros outside issue cycles
  assign dvr_fptoint_s_in = s1_vld_q ? rd_data : '0;
  assign cru_fptoint_in   = {s1_vld_q, cfg_q};
  assign wr_en            = s2_vld_q;
  assign wr_addr          = wr_addr_q;
  assign wr_data          = s2_vld_q ? dr_fptoint_d_out : '0;
  assign dbg_state        = state_q;

endmodule
